ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the execute ALU; captures the ALU result plus the instruction's side information and hands it to the memory stage through a valid/ready handshake.
- Resolves control flow from the ALU result: branch taken/not-taken, JAL/JALR target, and the PC redirect.
- Fills in results the ALU does not produce (LUI, JAL/JALR link value) and generates the register-file write enable.
- Two-entry skid buffer, so upstream sees a registered in_ready with no combinational ready path.

Parameters:
- XLEN, 64, datapath width.
- OP_W, 8, instruction-code width (execute-stage op encoding).
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept; registered.
- in_op  input  OP_W  instruction code.
- in_result  input  XLEN  ALU result.
- in_rs1_val  input  XLEN  rs1 value (JALR base).
- in_rs2_val  input  XLEN  rs2 value (store data).
- in_imm  input  XLEN  raw immediate.
- in_pc  input  XLEN  instruction PC.
- in_rd  input  RD_W  destination register.
- flush  input  1  synchronous kill of all held entries.
- out_valid  output  1  entry valid to the memory stage.
- out_ready  input  1  memory stage accepts.
- out_op  output  OP_W  instruction code.
- out_result  output  XLEN  final result or effective address.
- out_store_data  output  XLEN  store data.
- out_rd  output  RD_W  destination register.
- out_rd_we  output  1  register write enable.
- out_pc  output  XLEN  instruction PC.
- redirect_valid  output  1  one-cycle fetch-redirect pulse.
- redirect_pc  output  XLEN  redirect target.

Behaviour:
- Reset: all outputs are 0, both entries are invalid, in_ready=1.
- Accept occurs when in_valid & in_ready. Transfer occurs when out_valid & out_ready.
- Storage is a main register driving the out_* ports and a skid register.
- Occupancy states:
  - EMPTY → ONE on accept.
  - ONE → EMPTY on transfer with no accept.
  - ONE → ONE on transfer and accept together.
  - ONE → TWO on accept with no transfer; the incoming entry goes to skid.
  - TWO → ONE on transfer; skid moves to main.
- in_ready = (state != TWO), registered. In TWO, input is ignored.
- Latency: an accept at cycle N gives out_valid at N+1. Throughput is 1 per cycle while out_ready=1.
- Result substitution is applied at capture:
  - LUI (55): out_result = sign-extend(in_imm[19:0]) << 12.
  - JAL (53) and JALR (54): out_result = in_pc + 4.
  - All other ops: out_result = in_result. Loads/stores (43–46, 59–65) pass the address through.
- Branches (47–52): taken = in_result[0]. out_result = {63'b0, taken}.
- out_rd_we = 1 for ops 0–42, 53–56 and 59–65 with in_rd != 0. It is 0 otherwise, including stores, branches, ECALL (57) and EBREAK (58).
- Redirect is registered and asserts for exactly one cycle, the cycle after accept:
  - Taken branch: target in_pc + in_imm.
  - JAL: target in_pc + in_imm.
  - JALR: target (in_rs1_val + in_imm) & ~64'h1.
  - Not-taken branch and all other ops: no pulse.
- Flush: highest priority. On the next edge both entries are cleared, state → EMPTY and in_ready=1.
  - An accept in the same cycle as flush is dropped.
  - A redirect from an input accepted in the flush cycle is suppressed.
  - A redirect already registered still drives that cycle.
- Width arithmetic is modulo 2^XLEN; PC wrap-around is not trapped.
- Unknown op codes pass through with out_rd_we=0.
- Reset asserted mid-operation clears everything asynchronously. Deassertion is not gated on handshake state.
- While out_valid=1 and out_ready=0, all out_* ports hold stable.

Optional Feature:
- Macro: EX_MEM_PERF_CNT_EN.
- Defined: two extra ports are added, perf_taken (output, 32 bits) and perf_stall (output, 32 bits).
  - perf_taken counts redirect pulses.
  - perf_stall counts cycles with out_valid & !out_ready.
  - Both counters wrap at 2^32, reset to 0, and are unaffected by flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- ADD, in_result=0x5, rd=3, out_ready=1 → next cycle out_valid=1, out_result=0x5, out_rd_we=1. Same with rd=0 → out_rd_we=0.
- BEQ (47), in_result=1, pc=0x1000, imm=0x20 → redirect_valid pulses for 1 cycle, redirect_pc=0x1020, out_rd_we=0. With in_result=0 → no pulse.
- JALR (54), rs1=0x2003, imm=0x4, pc=0x3000, rd=1 → redirect_pc=0x2006, out_result=0x3004, out_rd_we=1.
- out_ready=0 and 3 back-to-back inputs A, B, C → A and B accepted, in_ready=0 while C is held. Release out_ready → A, B, C emerge in order, no loss or duplication.
- State TWO, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, no redirect from the dropped input.
- LUI (55), imm=0x80000 → out_result=0xFFFFFFFF80000000. rst_n pulsed low mid-transfer → all outputs 0 immediately.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: result fix-up, branch/jump resolution and a 2-entry skid buffer.
// Optional perf counters are enabled by defining EX_MEM_PERF_CNT_EN.
module ex_mem_stage #(
    parameter int XLEN = 64,
    parameter int OP_W = 8,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RD_W-1:0] in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_op,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [RD_W-1:0] out_rd,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_pc,
`ifdef EX_MEM_PERF_CNT_EN
    output logic [31:0]     perf_taken,
    output logic [31:0]     perf_stall,
`endif
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [OP_W-1:0] OP_ALU_LAST = OP_W'(42);
    localparam logic [OP_W-1:0] OP_BR_FIRST = OP_W'(47);
    localparam logic [OP_W-1:0] OP_BR_LAST  = OP_W'(52);
    localparam logic [OP_W-1:0] OP_JAL      = OP_W'(53);
    localparam logic [OP_W-1:0] OP_JALR     = OP_W'(54);
    localparam logic [OP_W-1:0] OP_LUI      = OP_W'(55);
    localparam logic [OP_W-1:0] OP_WB_MID   = OP_W'(56);
    localparam logic [OP_W-1:0] OP_LD_FIRST = OP_W'(59);
    localparam logic [OP_W-1:0] OP_LD_LAST  = OP_W'(65);

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store_data;
        logic [RD_W-1:0] rd;
        logic            rd_we;
        logic [XLEN-1:0] pc;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t          state;
    entry_t          main_q, skid_q, cap;
    logic            cap_redir;
    logic [XLEN-1:0] cap_tgt;
    logic            accept, xfer, is_branch, taken;

    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;
    assign is_branch = (in_op >= OP_BR_FIRST) && (in_op <= OP_BR_LAST);
    assign taken     = is_branch & in_result[0];

    always_comb begin
        cap.op         = in_op;
        cap.result     = in_result;
        cap.store_data = in_rs2_val;
        cap.rd         = in_rd;
        cap.pc         = in_pc;
        cap.rd_we      = (in_rd != '0) &&
                         ((in_op <= OP_ALU_LAST) ||
                          ((in_op >= OP_JAL) && (in_op <= OP_WB_MID)) ||
                          ((in_op >= OP_LD_FIRST) && (in_op <= OP_LD_LAST)));
        cap_redir      = 1'b0;
        cap_tgt        = in_pc + in_imm;
        if (is_branch) begin
            cap.result = {{(XLEN-1){1'b0}}, taken};
            cap_redir  = taken;
        end else if (in_op == OP_JAL) begin
            cap.result = in_pc + XLEN'(4);
            cap_redir  = 1'b1;
        end else if (in_op == OP_JALR) begin
            cap.result = in_pc + XLEN'(4);
            cap_redir  = 1'b1;
            cap_tgt    = (in_rs1_val + in_imm) & ~XLEN'(1);
        end else if (in_op == OP_LUI) begin
            cap.result = {{(XLEN-20){in_imm[19]}}, in_imm[19:0]} << 12;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= EMPTY;
            main_q         <= '0;
            skid_q         <= '0;
            out_valid      <= 1'b0;
            in_ready       <= 1'b1;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (flush) begin
            // Accept in the flush cycle is dropped, so its redirect never fires.
            state          <= EMPTY;
            out_valid      <= 1'b0;
            in_ready       <= 1'b1;
            redirect_valid <= 1'b0;
        end else begin
            redirect_valid <= accept & cap_redir;
            if (accept & cap_redir)
                redirect_pc <= cap_tgt;
            unique case (state)
                EMPTY: if (accept) begin
                    main_q    <= cap;
                    out_valid <= 1'b1;
                    state     <= ONE;
                end
                ONE: begin
                    if (xfer && accept) begin
                        main_q <= cap;
                    end else if (xfer) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end else if (accept) begin
                        skid_q   <= cap;
                        in_ready <= 1'b0;
                        state    <= TWO;
                    end
                end
                TWO: if (xfer) begin
                    main_q   <= skid_q;
                    in_ready <= 1'b1;
                    state    <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_op         = main_q.op;
    assign out_result     = main_q.result;
    assign out_store_data = main_q.store_data;
    assign out_rd         = main_q.rd;
    assign out_rd_we      = main_q.rd_we;
    assign out_pc         = main_q.pc;

`ifdef EX_MEM_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_taken <= '0;
            perf_stall <= '0;
        end else begin
            if (redirect_valid)
                perf_taken <= perf_taken + 32'd1;
            if (out_valid && !out_ready)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
